// File: rtl/ibex_mem_arbiter_if.sv
// Bus bundle between the Ibex fetch/LSU requesters, the shared RAM port and the arbiter.
// The arbiter uses the slave modport; the requesters and the RAM model use the master modport.
interface ibex_mem_arbiter_if;
    // Instruction fetch port
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;

    // Data (LSU) port
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;

    // Single-port RAM side
    logic        mem_req;
    logic        mem_write;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  instr_req, instr_addr,
        output instr_gnt, instr_rvalid, instr_rdata, instr_err,
        input  data_req, data_we, data_be, data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata, data_err,
        output mem_req, mem_write, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output instr_req, instr_addr,
        input  instr_gnt, instr_rvalid, instr_rdata, instr_err,
        output data_req, data_we, data_be, data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata, data_err,
        input  mem_req, mem_write, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/ibex_mem_arbiter.sv
// Shares one single-port simulation RAM between the Ibex fetch and LSU ports.
// Fetch has priority; a saturating streak counter hands the slot to a waiting LSU request.
module ibex_mem_arbiter #(
    parameter int unsigned MEM_SIZE         = 65536,
    parameter logic [31:0] MEM_START        = 32'h0000_0000,
    parameter int unsigned MAX_INSTR_STREAK = 4
) (
    input  logic              clk_sys,
    input  logic              rst_sys,
    ibex_mem_arbiter_if.slave bus
);
    localparam logic [31:0] MEM_MASK   = 32'(MEM_SIZE - 1);
    localparam logic [3:0]  STREAK_MAX = 4'(MAX_INSTR_STREAK);
    localparam logic [3:0]  STREAK_SAT = 4'hF;

    // Streak counter and the one-deep response pipeline
    logic [3:0] r_streak_cnt;
    logic       r_resp_valid;
    logic       r_resp_port;
    logic       r_resp_err;
    logic       r_resp_we;

    logic        w_instr_in_range;
    logic        w_data_in_range;
    logic        w_instr_win;
    logic        w_data_win;
    logic        w_mem_req;
    logic        w_mem_write;
    logic [3:0]  w_mem_be;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_wdata;
    logic        w_instr_rvalid;
    logic        w_data_rvalid;

    // Address decode and winner selection; nothing is granted while in reset
    always_comb begin
        w_instr_in_range = (bus.instr_addr & ~MEM_MASK) == MEM_START;
        w_data_in_range  = (bus.data_addr  & ~MEM_MASK) == MEM_START;
        w_data_win       = !rst_sys && bus.data_req &&
                           (!bus.instr_req || (r_streak_cnt >= STREAK_MAX));
        w_instr_win      = !rst_sys && bus.instr_req && !w_data_win;
    end

    // RAM port: driven from the winner only when it decodes into the window
    always_comb begin
        w_mem_req   = 1'b0;
        w_mem_write = 1'b0;
        w_mem_be    = 4'h0;
        w_mem_addr  = 32'h0;
        w_mem_wdata = 32'h0;
        if (w_instr_win && w_instr_in_range) begin
            w_mem_req  = 1'b1;
            w_mem_be   = 4'hF;
            w_mem_addr = bus.instr_addr;
        end else if (w_data_win && w_data_in_range) begin
            w_mem_req   = 1'b1;
            w_mem_write = bus.data_we;
            w_mem_be    = bus.data_be;
            w_mem_addr  = bus.data_addr;
            w_mem_wdata = bus.data_wdata;
        end
    end

    // Response state and streak tracking
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            r_resp_valid <= 1'b0;
            r_resp_port  <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_we    <= 1'b0;
            r_streak_cnt <= 4'h0;
        end else begin
            r_resp_valid <= w_instr_win || w_data_win;
            if (w_instr_win) begin
                r_resp_port <= 1'b0;
                r_resp_err  <= !w_instr_in_range;
                r_resp_we   <= 1'b0;
            end else if (w_data_win) begin
                r_resp_port <= 1'b1;
                r_resp_err  <= !w_data_in_range;
                r_resp_we   <= bus.data_we;
            end

            if (w_data_win || !bus.data_req) begin
                r_streak_cnt <= 4'h0;
            end else if (w_instr_win && (r_streak_cnt != STREAK_SAT)) begin
                r_streak_cnt <= r_streak_cnt + 4'h1;
            end
        end
    end

    // Response routing; a response still in the pipe when reset hits is dropped
    always_comb begin
        w_instr_rvalid = !rst_sys && r_resp_valid && !r_resp_port;
        w_data_rvalid  = !rst_sys && r_resp_valid &&  r_resp_port;
    end

    assign bus.instr_gnt    = w_instr_win;
    assign bus.data_gnt     = w_data_win;

    assign bus.mem_req      = w_mem_req;
    assign bus.mem_write    = w_mem_write;
    assign bus.mem_be       = w_mem_be;
    assign bus.mem_addr     = w_mem_addr;
    assign bus.mem_wdata    = w_mem_wdata;

    assign bus.instr_rvalid = w_instr_rvalid;
    assign bus.instr_err    = w_instr_rvalid && r_resp_err;
    assign bus.instr_rdata  = (w_instr_rvalid && !r_resp_err) ? bus.mem_rdata : 32'h0;

    // Write acknowledgements carry no data
    assign bus.data_rvalid  = w_data_rvalid;
    assign bus.data_err     = w_data_rvalid && r_resp_err;
    assign bus.data_rdata   = (w_data_rvalid && !r_resp_err && !r_resp_we) ? bus.mem_rdata : 32'h0;

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Directed bench for ibex_mem_arbiter: hand-checked scenarios plus a per-cycle reference model.
module tb_ibex_mem_arbiter;
    localparam int unsigned MEM_SIZE  = 65536;
    localparam int unsigned MAX_STRK  = 4;
    localparam int unsigned WORDS     = MEM_SIZE / 4;

    logic clk;
    logic rst;
    ibex_mem_arbiter_if bus ();

    ibex_mem_arbiter #(
        .MEM_SIZE        (MEM_SIZE),
        .MEM_START       (32'h0000_0000),
        .MAX_INSTR_STREAK(MAX_STRK)
    ) dut (
        .clk_sys(clk),
        .rst_sys(rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // RAM seen by the DUT: registered read, byte-enabled write
    logic [31:0] ram [WORDS];
    always @(posedge clk) begin
        if (bus.mem_req) begin
            if (bus.mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) ram[bus.mem_addr[15:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                bus.mem_rdata <= ram[bus.mem_addr[15:2]];
            end
        end
    end

    // Reference model state: its own copy of memory, streak length, pending response
    logic [31:0] ref_mem [WORDS];
    int          m_streak   = 0;
    bit          pend_valid = 0;
    bit          pend_port  = 0;
    bit          pend_err   = 0;
    logic [31:0] pend_data  = '0;

    function automatic bit in_win(input logic [31:0] a);
        return (a & ~32'(MEM_SIZE - 1)) == 32'h0;
    endfunction

    int          winner;
    bit          e_ir, e_dr;
    logic        e_ig, e_dg, e_mreq, e_mwr;
    logic [3:0]  e_mbe;
    logic [31:0] e_maddr, e_mwd;
    logic        e_irv, e_ierr, e_drv, e_derr;
    logic [31:0] e_ird, e_drd;

    // Compare every cycle at the falling edge, then advance the model to the next cycle
    always @(negedge clk) begin
        e_ir = in_win(bus.instr_addr);
        e_dr = in_win(bus.data_addr);
        winner = 0;
        if (!rst) begin
            if (bus.instr_req && !bus.data_req)      winner = 1;
            else if (!bus.instr_req && bus.data_req) winner = 2;
            else if (bus.instr_req && bus.data_req)  winner = (m_streak < int'(MAX_STRK)) ? 1 : 2;
        end
        e_ig = (winner == 1);
        e_dg = (winner == 2);
        e_mreq = 0; e_mwr = 0; e_mbe = 4'h0; e_maddr = 32'h0; e_mwd = 32'h0;
        if (winner == 1 && e_ir) begin
            e_mreq = 1; e_mbe = 4'hF; e_maddr = bus.instr_addr;
        end
        if (winner == 2 && e_dr) begin
            e_mreq = 1; e_mwr = bus.data_we; e_mbe = bus.data_be;
            e_maddr = bus.data_addr; e_mwd = bus.data_wdata;
        end
        e_irv  = !rst && pend_valid && !pend_port;
        e_drv  = !rst && pend_valid &&  pend_port;
        e_ierr = e_irv && pend_err;
        e_derr = e_drv && pend_err;
        e_ird  = e_irv ? pend_data : 32'h0;
        e_drd  = e_drv ? pend_data : 32'h0;

        chk("m_gnt", 128'({bus.instr_gnt, bus.data_gnt}), 128'({e_ig, e_dg}));
        chk("m_mem", 128'({bus.mem_req, bus.mem_write, bus.mem_be, bus.mem_addr, bus.mem_wdata}),
                     128'({e_mreq, e_mwr, e_mbe, e_maddr, e_mwd}));
        chk("m_iresp", 128'({bus.instr_rvalid, bus.instr_err, bus.instr_rdata}), 128'({e_irv, e_ierr, e_ird}));
        chk("m_dresp", 128'({bus.data_rvalid, bus.data_err, bus.data_rdata}), 128'({e_drv, e_derr, e_drd}));

        if (rst) begin
            m_streak   = 0;
            pend_valid = 0;
        end else begin
            pend_valid = (winner != 0);
            if (winner == 1) begin
                pend_port = 0;
                pend_err  = !e_ir;
                pend_data = e_ir ? ref_mem[bus.instr_addr[15:2]] : 32'h0;
            end else if (winner == 2) begin
                pend_port = 1;
                pend_err  = !e_dr;
                pend_data = (e_dr && !bus.data_we) ? ref_mem[bus.data_addr[15:2]] : 32'h0;
                if (e_dr && bus.data_we)
                    for (int b = 0; b < 4; b++)
                        if (bus.data_be[b]) ref_mem[bus.data_addr[15:2]][8*b +: 8] = bus.data_wdata[8*b +: 8];
            end
            if (winner == 2 || !bus.data_req) m_streak = 0;
            else if (winner == 1)             m_streak = (m_streak < 15) ? m_streak + 1 : 15;
            chk("m_streak_bound", 128'(m_streak <= int'(MAX_STRK)), 128'(1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic string gch();
        if (bus.instr_gnt) return "I";
        if (bus.data_gnt)  return "D";
        return "-";
    endfunction

    task automatic chk_seq(input string name, input string act, input string exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %s expected %s", name, $time, act, exp);
        end
    endtask

    string seq;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.instr_req = 0; bus.instr_addr = 0;
        bus.data_req = 0; bus.data_we = 0; bus.data_be = 4'hF; bus.data_addr = 0; bus.data_wdata = 0;
        bus.mem_rdata = 32'h0;
        for (int i = 0; i < int'(WORDS); i++) begin
            ram[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        ram[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;

        // Reset held with both requesters active
        bus.instr_req = 1; bus.instr_addr = 32'h10;
        bus.data_req = 1;  bus.data_addr = 32'h20;
        for (int i = 0; i < 3; i++) begin
            tick(); #3;
            chk("rst_gnt", 128'({bus.instr_gnt, bus.data_gnt}), 128'(0));
            chk("rst_rvalid", 128'({bus.instr_rvalid, bus.data_rvalid}), 128'(0));
            chk("rst_memreq", 128'(bus.mem_req), 128'(0));
        end
        tick(); rst = 1'b0; #3;
        chk("first_igrant", 128'({bus.instr_gnt, bus.data_gnt}), 128'(2'b10));

        // Contention: both held for ten cycles
        seq = "";
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin tick(); #3; end
            seq = {seq, gch()};
        end
        chk_seq("contention_seq", seq, "IIIIDIIIID");
        tick(); bus.instr_req = 0; bus.data_req = 0;
        tick();

        // Single fetch
        bus.instr_req = 1; bus.instr_addr = 32'h10; #3;
        chk("fetch_gnt", 128'({bus.instr_gnt, bus.mem_req, bus.mem_write, bus.mem_be, bus.mem_addr}),
                         128'({1'b1, 1'b1, 1'b0, 4'hF, 32'h10}));
        tick(); bus.instr_req = 0; #3;
        chk("fetch_resp", 128'({bus.instr_rvalid, bus.instr_err, bus.instr_rdata}), 128'({1'b1, 1'b0, 32'hDEADBEEF}));

        // Out-of-range read
        tick(); bus.data_req = 1; bus.data_we = 0; bus.data_be = 4'hF; bus.data_addr = 32'h0001_0000; #3;
        chk("oor_gnt", 128'({bus.data_gnt, bus.mem_req}), 128'(2'b10));
        tick(); bus.data_req = 0; #3;
        chk("oor_resp", 128'({bus.data_rvalid, bus.data_err, bus.data_rdata}), 128'({1'b1, 1'b1, 32'h0}));

        // Byte write then back-to-back read of the same word
        tick(); bus.data_req = 1; bus.data_we = 1; bus.data_be = 4'b0010;
        bus.data_addr = 32'h100; bus.data_wdata = 32'h0000AB00; #3;
        chk("bw_gnt", 128'({bus.data_gnt, bus.mem_req, bus.mem_write, bus.mem_be}), 128'({3'b111, 4'b0010}));
        tick(); bus.data_we = 0; bus.data_be = 4'hF; bus.data_wdata = 0; #3;
        chk("bw_resp", 128'({bus.data_rvalid, bus.data_err, bus.data_rdata}), 128'({1'b1, 1'b0, 32'h0}));
        chk("br_gnt", 128'(bus.data_gnt), 128'(1));
        tick(); bus.data_req = 0; #3;
        chk("br_resp", 128'({bus.data_rvalid, bus.data_err, bus.data_rdata}), 128'({1'b1, 1'b0, 32'h0000AB00}));

        // Out-of-range write must not alias onto the RAM
        tick(); bus.data_req = 1; bus.data_we = 1; bus.data_addr = 32'h0001_0100; bus.data_wdata = 32'hFFFFFFFF; #3;
        chk("oorw_memreq", 128'({bus.data_gnt, bus.mem_req}), 128'(2'b10));
        tick(); bus.data_we = 0; bus.data_addr = 32'h100; bus.data_wdata = 0; #3;
        chk("oorw_resp", 128'({bus.data_rvalid, bus.data_err}), 128'(2'b11));
        tick(); bus.data_req = 0; #3;
        chk("oorw_keep", 128'(bus.data_rdata), 128'(32'h0000AB00));

        // Reset mid-flight drops the owed response
        tick(); bus.data_req = 1; #3;
        chk("mf_gnt", 128'(bus.data_gnt), 128'(1));
        tick(); rst = 1'b1; bus.data_req = 0; #3;
        chk("mf_drop", 128'({bus.data_rvalid, bus.data_rdata}), 128'(0));
        tick(); rst = 1'b0;

        // Reset clears a partial streak
        bus.instr_req = 1; bus.instr_addr = 32'h14; bus.data_req = 1; bus.data_addr = 32'h100;
        seq = "";
        for (int i = 0; i < 3; i++) begin #3; seq = {seq, gch()}; tick(); end
        rst = 1'b1; #3;
        chk("rs_gnt", 128'({bus.instr_gnt, bus.data_gnt}), 128'(0));
        tick(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin #3; seq = {seq, gch()}; tick(); end
        chk_seq("reset_streak_seq", seq, "IIIIIIID");

        // A cycle without a data request also clears the streak
        seq = "";
        for (int i = 0; i < 3; i++) begin #3; seq = {seq, gch()}; tick(); end
        bus.data_req = 0; #3; seq = {seq, gch()}; tick();
        bus.data_req = 1;
        for (int i = 0; i < 5; i++) begin #3; seq = {seq, gch()}; tick(); end
        chk_seq("idle_clear_seq", seq, "IIIIIIIID");

        bus.instr_req = 0; bus.data_req = 0;
        tick(); tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
